// File: rtl/minibit_exec_unit_if.sv
// Command/result bundle for minibit_exec_unit.
//   cmd_valid/cmd_ready   : command handshake
//   cmd_op/dst/srca/srcb  : operation code and register indices
//   cmd_data              : immediate value used by LOAD
//   res_valid/res_data    : one-cycle completion pulse and its result
//   fl_carry/fl_lt/fl_zero: registered flags
//   dbg_state             : FSM state (IDLE=0, FETCH=1, EXEC=2, WB=3)
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while the unit is idle.
// The master may raise cmd_valid at any time. Every cmd_* field is captured
// on the transfer edge. res_valid carries no backpressure; it is high for
// exactly one cycle per completed command.
interface minibit_exec_unit_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_dst;
  logic [AW-1:0]    cmd_srca;
  logic [AW-1:0]    cmd_srcb;
  logic [WIDTH-1:0] cmd_data;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             fl_carry;
  logic             fl_lt;
  logic             fl_zero;
  logic [1:0]       dbg_state;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_data,
    input  cmd_ready, res_valid, res_data, fl_carry, fl_lt, fl_zero, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_data,
    output cmd_ready, res_valid, res_data, fl_carry, fl_lt, fl_zero, dbg_state
  );
endinterface

// File: rtl/minibit_exec_unit.sv
// Small multi-cycle execution unit: a REGS x WIDTH register file driven by
// one command at a time through a four-state FSM (IDLE, FETCH, EXEC, WB).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : minibit_exec_unit_if.slave (command, result, flags, dbg_state)
module minibit_exec_unit #(
  parameter int WIDTH = 8,
  parameter int REGS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  minibit_exec_unit_if.slave     bus
);
  localparam int AW = $clog2(REGS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d, srca_q, srca_d, srcb_q, srcb_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             nc_q, nc_d, nl_q, nl_d, nz_q, nz_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             fl_carry_q, fl_carry_d, fl_lt_q, fl_lt_d, fl_zero_q, fl_zero_d;
  logic [WIDTH-1:0] regs_q [REGS];
  logic [WIDTH-1:0] regs_d [REGS];

  // Arithmetic is done one bit wider so the top bit is the carry out.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   cin;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    data_d      = data_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    nc_d        = nc_q;
    nl_d        = nl_q;
    nz_d        = nz_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    fl_carry_d  = fl_carry_q;
    fl_lt_d     = fl_lt_q;
    fl_zero_d   = fl_zero_q;
    regs_d      = regs_q;
    sum         = '0;
    cin         = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          dst_d   = bus.cmd_dst;
          srca_d  = bus.cmd_srca;
          srcb_d  = bus.cmd_srcb;
          data_d  = bus.cmd_data;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Operands are sampled here, so a destination that aliases a source
        // still sees the pre-write value.
        a_d     = (op_q == OP_LOAD) ? data_q : regs_q[srca_q];
        b_d     = regs_q[srcb_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        nc_d = fl_carry_q;
        case (op_q)
          OP_LOAD: result_d = a_q;
          OP_ADD, OP_ADC: begin
            cin[0]   = (op_q == OP_ADC) ? fl_carry_q : 1'b0;
            sum      = {1'b0, a_q} + {1'b0, b_q} + cin;
            result_d = sum[WIDTH-1:0];
            nc_d     = sum[WIDTH];
          end
          OP_SUB, OP_CMP: begin
            // Carry set means no borrow.
            cin[0]   = 1'b1;
            sum      = {1'b0, a_q} + {1'b0, ~b_q} + cin;
            result_d = sum[WIDTH-1:0];
            nc_d     = sum[WIDTH];
          end
          OP_NAND: result_d = ~(a_q & b_q);
          OP_SHL: begin
            result_d = {a_q[WIDTH-2:0], 1'b0};
            nc_d     = a_q[WIDTH-1];
          end
          default: begin
            result_d = {1'b0, a_q[WIDTH-1:1]};
            nc_d     = a_q[0];
          end
        endcase
        nz_d    = (result_d == '0);
        nl_d    = (a_q < b_q);
        state_d = S_WB;
      end
      default: begin
        if (op_q != OP_CMP) regs_d[dst_q] = result_q;
        if (op_q != OP_LOAD) begin
          fl_carry_d = nc_q;
          fl_lt_d    = nl_q;
          fl_zero_d  = nz_q;
        end
        res_valid_d = 1'b1;
        res_data_d  = result_q;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      data_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      nc_q        <= 1'b0;
      nl_q        <= 1'b0;
      nz_q        <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      fl_carry_q  <= 1'b0;
      fl_lt_q     <= 1'b0;
      fl_zero_q   <= 1'b0;
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      data_q      <= data_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      nc_q        <= nc_d;
      nl_q        <= nl_d;
      nz_q        <= nz_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      fl_carry_q  <= fl_carry_d;
      fl_lt_q     <= fl_lt_d;
      fl_zero_q   <= fl_zero_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.fl_carry  = fl_carry_q;
  assign bus.fl_lt     = fl_lt_q;
  assign bus.fl_zero   = fl_zero_q;
  assign bus.dbg_state = state_q;
endmodule
